gmii_tx_frame_ctrl: RTL and testbench

//  Transmit-side frame sequencer for one GMII port. Takes a byte stream

---
 rtl/gmii_tx_frame_ctrl_if.sv | 11 +
 rtl/gmii_tx_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_gmii_tx_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gmii_tx_frame_ctrl_if.sv
// Egress byte stream between the switch egress queue (master) and the
// GMII transmit frame sequencer (slave).
interface gmii_tx_frame_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/gmii_tx_frame_ctrl.sv
// GMII transmit frame sequencer: preamble/SFD, payload, zero pad to the
// minimum frame size, FCS from an external CRC-32 engine, then the
// inter-frame gap. Underruns and oversize frames are flagged with tx_er
// and the remainder of the frame is drained from the egress queue.
module gmii_tx_frame_ctrl #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514,
  parameter int IFG_LEN = 12,
  parameter int PRE_LEN = 7
) (
  input  logic                       clk,
  input  logic                       rstn,
  gmii_tx_frame_ctrl_if.slave        s_in,
  output logic                       crc_load_init,
  output logic                       crc_calc,
  output logic                       crc_d_valid,
  output logic [7:0]                 crc_d,
  input  logic [7:0]                 crc_byte,
  output logic [7:0]                 gmii_txd,
  output logic                       gmii_tx_en,
  output logic                       gmii_tx_er,
  output logic                       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_DRAIN,
    S_IFG
  } state_t;

  state_t      r_state;
  logic [10:0] r_byte_cnt;
  logic [3:0]  r_cnt;

  logic        w_hs;
  logic        w_ovf;
  logic        w_short;

  // Handshake qualifiers and engine/queue controls decoded from the current state
  always_comb begin
    s_in.in_ready = (r_state == S_DATA) || (r_state == S_DRAIN);
    w_hs          = s_in.in_valid & s_in.in_ready;
    w_ovf         = (r_byte_cnt == 11'(MAX_LEN));
    w_short       = ({1'b0, r_byte_cnt} + 12'd1) < 12'(MIN_LEN);

    crc_load_init = (r_state == S_SFD);
    crc_calc      = 1'b0;
    crc_d_valid   = 1'b0;
    crc_d         = 8'h00;
    case (r_state)
      S_DATA: begin
        // The byte that trips the size limit is never transmitted, so it
        // must not reach the engine either.
        crc_calc    = w_hs & ~w_ovf;
        crc_d_valid = w_hs & ~w_ovf;
        crc_d       = s_in.in_data;
      end
      S_PAD: begin
        crc_calc    = 1'b1;
        crc_d_valid = 1'b1;
      end
      S_FCS: begin
        crc_d_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != S_IDLE);

  // Frame sequencer with registered GMII outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_cnt      <= '0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
    end else begin
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (s_in.in_valid) begin
            r_state <= S_PREAMBLE;
            r_cnt   <= '0;
          end
        end
        S_PREAMBLE: begin
          gmii_txd   <= 8'h55;
          gmii_tx_en <= 1'b1;
          if (r_cnt == 4'(PRE_LEN - 1)) begin
            r_state <= S_SFD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_SFD: begin
          gmii_txd   <= 8'hD5;
          gmii_tx_en <= 1'b1;
          r_byte_cnt <= '0;
          r_state    <= S_DATA;
        end
        S_DATA: begin
          gmii_tx_en <= 1'b1;
          r_cnt      <= '0;
          if (!s_in.in_valid) begin
            // Underrun: corrupt the frame on the wire and swallow the rest.
            gmii_tx_er <= 1'b1;
            r_state    <= S_DRAIN;
          end else if (w_ovf) begin
            // Oversize: this byte already ends the frame if it is the last.
            gmii_tx_er <= 1'b1;
            r_state    <= s_in.in_last ? S_IFG : S_DRAIN;
          end else begin
            // Only reached below MAX_LEN, so the count saturates there.
            gmii_txd   <= s_in.in_data;
            r_byte_cnt <= r_byte_cnt + 11'd1;
            if (s_in.in_last) begin
              r_state <= w_short ? S_PAD : S_FCS;
            end
          end
        end
        S_PAD: begin
          gmii_tx_en <= 1'b1;
          r_byte_cnt <= r_byte_cnt + 11'd1;
          if (r_byte_cnt == 11'(MIN_LEN - 1)) begin
            r_state <= S_FCS;
            r_cnt   <= '0;
          end
        end
        S_FCS: begin
          gmii_txd   <= crc_byte;
          gmii_tx_en <= 1'b1;
          if (r_cnt == 4'd3) begin
            r_state <= S_IFG;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DRAIN: begin
          if (w_hs && s_in.in_last) begin
            r_state <= S_IFG;
            r_cnt   <= '0;
          end
        end
        S_IFG: begin
          if (r_cnt == 4'(IFG_LEN - 1)) begin
            r_cnt <= '0;
            // Skipping IDLE when a frame is waiting keeps the wire gap at
            // exactly IFG_LEN idle bytes between back-to-back frames.
            r_state <= s_in.in_valid ? S_PREAMBLE : S_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_frame_ctrl.sv
// Bench for gmii_tx_frame_ctrl: directed frames, a frame-level reference
// model (expected wire bytes built from payload + CRC-32), and a monitor
// that compares every wire byte and idle cycle against it.
module tb_gmii_tx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       crc_load_init, crc_calc, crc_d_valid;
  logic [7:0] crc_d, crc_byte;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, busy;

  gmii_tx_frame_ctrl_if bif();

  gmii_tx_frame_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .s_in          (bif.slave),
    .crc_load_init (crc_load_init),
    .crc_calc      (crc_calc),
    .crc_d_valid   (crc_d_valid),
    .crc_d         (crc_d),
    .crc_byte      (crc_byte),
    .gmii_txd      (gmii_txd),
    .gmii_tx_en    (gmii_tx_en),
    .gmii_tx_er    (gmii_tx_er),
    .busy          (busy)
  );

  always #4 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'd0, d};
    for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // CRC-32 engine behaviour seen by the sequencer
  logic [31:0] eng = 32'h0;
  always @(posedge clk) begin
    if (crc_load_init) eng <= 32'hFFFFFFFF;
    else if (crc_d_valid) eng <= crc_calc ? crc_step(eng, crc_d) : {8'hFF, eng[31:8]};
  end
  assign crc_byte = ~eng[7:0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] pay [0:2047];
  logic [8:0] exp_data[$];
  int         exp_len[$];
  int         last_model_len;

  // good < 0: complete frame; good >= 0: error after 'good' bytes.
  // trunc >= 0: only the first 'trunc' wire bytes are expected.
  task automatic model_frame(input int n, input int good, input int trunc);
    logic [8:0]  f[$];
    logic [31:0] c;
    logic [7:0]  b;
    int          padded;
    for (int i = 0; i < 7; i++) f.push_back({1'b0, 8'h55});
    f.push_back({1'b0, 8'hD5});
    if (good < 0) begin
      padded = (n < 60) ? 60 : n;
      c = 32'hFFFFFFFF;
      for (int i = 0; i < padded; i++) begin
        b = (i < n) ? pay[i] : 8'h00;
        f.push_back({1'b0, b});
        c = crc_step(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) f.push_back({1'b0, c[8*k +: 8]});
    end else begin
      for (int i = 0; i < good; i++) f.push_back({1'b0, pay[i]});
      f.push_back({1'b1, 8'h00});
    end
    if (trunc >= 0) while (f.size() > trunc) void'(f.pop_back());
    exp_len.push_back(f.size());
    foreach (f[i]) exp_data.push_back(f[i]);
    last_model_len = f.size();
  endtask

  // ---------------- monitor ----------------
  logic [8:0] cur[$];
  int         mon_len = 0;
  int         gap_cnt = 1000;
  int         exp_gap = -1;

  task automatic compare_frame();
    int n, shown;
    logic [8:0] e;
    shown = 0;
    if (exp_len.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_frame: got %0d bytes expected none", cur.size());
    end else begin
      n = exp_len.pop_front();
      chk("frame_len", cur.size(), n);
      for (int i = 0; i < n; i++) begin
        e = exp_data.pop_front();
        if (i < cur.size()) begin
          checks++;
          if (cur[i] !== e) begin
            errors++;
            if (shown < 4) $display("FAIL wire_byte[%0d]: got {er,txd}=0x%0h expected 0x%0h", i, cur[i], e);
            shown++;
          end
        end
      end
    end
    cur.delete();
    mon_len = 0;
  endtask

  always @(negedge clk) begin
    if (gmii_tx_en) begin
      if (cur.size() == 0 && exp_gap >= 0) begin
        chk("ifg_gap", gap_cnt, exp_gap);
        exp_gap = -1;
      end
      cur.push_back({gmii_tx_er, gmii_txd});
      mon_len = cur.size();
    end else begin
      chk("idle_tx_er", gmii_tx_er, 1'b0);
      if (cur.size() > 0) begin
        compare_frame();
        gap_cnt = 0;
      end
      gap_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_byte(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    bif.in_data = d; bif.in_valid = 1'b1; bif.in_last = last;
    forever begin
      @(negedge clk);
      if (bif.in_ready) break;
      if (++t > 3000) begin
        checks++; errors++;
        $display("FAIL handshake_timeout: got no in_ready expected in_ready=1");
        break;
      end
    end
    @(posedge clk); #1;
    bif.in_valid = 1'b0; bif.in_last = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) push_byte(pay[i], i == n - 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy && t < 5000);
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  initial begin
    logic [31:0] c;
    logic [7:0]  s9 [0:8];
    int          busy_cnt, t;

    bif.in_data = 8'h00; bif.in_valid = 1'b0; bif.in_last = 1'b0;

    // Model pins: standard CRC-32 check values
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crc_step(c, s9[i]);
    chk("model_crc_123456789", ~c, 32'hCBF43926);
    c = ~crc_step(32'hFFFFFFFF, 8'h00);
    chk("model_crc_00", c, 32'hD202EF8D);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_en", gmii_tx_en, 1'b0);
    chk("rst_tx_er", gmii_tx_er, 1'b0);
    chk("rst_txd", gmii_txd, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", bif.in_ready, 1'b0);
    chk("rst_crc_ctl", {crc_load_init, crc_calc, crc_d_valid}, 3'b000);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 1: 60-byte payload, no pad
    for (int i = 0; i < 60; i++) pay[i] = 8'(i);
    model_frame(60, -1, -1);
    chk("model_len_60", last_model_len, 72);
    send_frame(60);
    wait_idle();

    // 2: 10-byte payload, padded to 60
    for (int i = 0; i < 10; i++) pay[i] = 8'hA0 + 8'(i);
    model_frame(10, -1, -1);
    chk("model_len_10", last_model_len, 72);
    chk("model_pad_byte", exp_data[exp_data.size() - 5], 9'h000);
    send_frame(10);
    wait_idle();

    // 3: two 64-byte frames back-to-back
    for (int i = 0; i < 64; i++) pay[i] = 8'(i * 3);
    model_frame(64, -1, -1);
    send_frame(64);
    for (int i = 0; i < 64; i++) pay[i] = ~8'(i);
    model_frame(64, -1, -1);
    exp_gap = 12;
    send_frame(64);
    wait_idle();

    // 4: underrun after byte 20, remainder drained, then a 12-cycle gap
    for (int i = 0; i < 40; i++) pay[i] = 8'(i) ^ 8'h5A;
    model_frame(40, 20, -1);
    for (int i = 0; i < 20; i++) push_byte(pay[i], 1'b0);
    @(posedge clk); #1;
    for (int i = 20; i < 40; i++) push_byte(pay[i], i == 39);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
    end
    chk("drain_ifg_cycles", busy_cnt, 12);
    wait_idle();

    // 5: oversize frame, abort at byte 1515, rest drained
    for (int i = 0; i < 1518; i++) pay[i] = 8'(i) ^ 8'(i >> 8);
    model_frame(1518, 1514, -1);
    send_frame(1518);
    wait_idle();

    // 6: reset while the FCS is going out, then a clean frame
    for (int i = 0; i < 60; i++) pay[i] = 8'(i * 7);
    model_frame(60, -1, 69);
    send_frame(60);
    t = 0;
    while (mon_len < 69 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    chk("fcs_reached", mon_len, 69);
    rstn = 1'b0;
    @(negedge clk);
    chk("midrst_tx_en", gmii_tx_en, 1'b0);
    chk("midrst_tx_er", gmii_tx_er, 1'b0);
    chk("midrst_txd", gmii_txd, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    @(posedge clk); #1 rstn = 1'b1;
    for (int i = 0; i < 12; i++) pay[i] = 8'hC0 | 8'(i);
    model_frame(12, -1, -1);
    send_frame(12);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("frames_outstanding", exp_len.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
